// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245-style FIFO responder.
package ft245_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned SYNC_STAGES     = 2;
    localparam int unsigned DEF_FIFO_DEPTH  = 128;
    localparam int unsigned DEF_HOLD_CYCLES = 2;

    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ       = 2'd1,
        ST_WRITE_HOLD = 2'd2,
        ST_READ_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/byte_sync_fifo.sv
// Single-clock byte FIFO; full/empty reflect the count at the start of the cycle.
module byte_sync_fifo
    import ft245_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  push_i,
    input  byte_t wdata_i,
    input  logic  pop_i,
    output byte_t rdata_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    byte_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign push_ok_c = push_i & ~full_q;
    assign pop_ok_c  = pop_i & ~empty_q;

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/ft245_fifo_responder.sv
// Device-side FT245 async FIFO responder: answers host rd_n/wr_n strobes and
// bridges bytes to/from two internal FIFOs exposed as valid/ready streams.
module ft245_fifo_responder
    import ft245_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_rd_n,
    input  logic              in_wr_n,
    output logic              out_rxf_n,
    output logic              out_txe_n,
    inout  wire  [DATA_W-1:0] io_data,
    input  logic [DATA_W-1:0] in_src_data,
    input  logic              in_src_valid,
    output logic              out_src_ready,
    output logic [DATA_W-1:0] out_snk_data,
    output logic              out_snk_valid,
    input  logic              in_snk_ready,
    output logic              out_collision
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;

    logic [SYNC_STAGES-1:0]             rst_sync_q;
    logic                               rst_core_n;
    logic [SYNC_STAGES-1:0]             rd_sync_q;
    logic [SYNC_STAGES-1:0]             wr_sync_q;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q;
    logic                               rd_prev_q;
    logic                               wr_prev_q;
    logic                               rd_s, wr_s;
    logic                               rd_fall_c, rd_rise_c, wr_fall_c;
    byte_t                              data_s;

    state_e                             state_q, state_d;
    logic [HOLD_W-1:0]                  hold_cnt_q, hold_cnt_d;
    byte_t                              dout_q, dout_d;
    logic                               rxf_n_q, rxf_n_d;
    logic                               txe_n_q, txe_n_d;
    logic                               collision_q, collision_d;
    logic                               bus_en_c;

    logic                               th_push_c, th_pop_c, th_full, th_empty;
    byte_t                              th_rdata;
    logic                               fh_push_c, fh_pop_c, fh_full, fh_empty;
    byte_t                              fh_rdata;

    // Reset: asserted asynchronously, released two clocks after in_rst_n rises.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end
    assign rst_core_n = rst_sync_q[SYNC_STAGES-1];

    // Strobe/data synchronizers plus one extra flop for edge detection.
    always_ff @(posedge in_clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            rd_sync_q   <= '1;
            wr_sync_q   <= '1;
            data_sync_q <= '0;
            rd_prev_q   <= 1'b1;
            wr_prev_q   <= 1'b1;
        end else begin
            rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], in_rd_n};
            wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], in_wr_n};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], io_data};
            rd_prev_q   <= rd_sync_q[SYNC_STAGES-1];
            wr_prev_q   <= wr_sync_q[SYNC_STAGES-1];
        end
    end

    assign rd_s      = rd_sync_q[SYNC_STAGES-1];
    assign wr_s      = wr_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign rd_fall_c = rd_prev_q & ~rd_s;
    assign rd_rise_c = ~rd_prev_q & rd_s;
    assign wr_fall_c = wr_prev_q & ~wr_s;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        dout_d      = dout_q;
        collision_d = 1'b0;
        th_pop_c    = 1'b0;
        fh_push_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_fall_c) begin
                    if (!th_empty) begin
                        dout_d  = th_rdata;
                        state_d = ST_READ;
                    end
                end else if (wr_fall_c) begin
                    // A write into a full FIFO is dropped without a hold period.
                    if (!fh_full) begin
                        fh_push_c  = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = ST_WRITE_HOLD;
                    end
                end
            end
            ST_READ: begin
                if (wr_fall_c) begin
                    collision_d = 1'b1;
                end
                if (rd_rise_c) begin
                    th_pop_c   = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_READ_HOLD;
                end
            end
            ST_WRITE_HOLD, ST_READ_HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rxf_n_d = (state_d == ST_READ) || (state_d == ST_READ_HOLD) || th_empty;
        txe_n_d = (state_d == ST_WRITE_HOLD) || fh_full;
    end

    always_ff @(posedge in_clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            dout_q      <= '0;
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b1;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            dout_q      <= dout_d;
            rxf_n_q     <= rxf_n_d;
            txe_n_q     <= txe_n_d;
            collision_q <= collision_d;
        end
    end

    // Release the bus in the same cycle the read strobe rise is detected.
    assign bus_en_c = (state_q == ST_READ) && !rd_rise_c;
    assign io_data  = bus_en_c ? dout_q : {DATA_W{1'bz}};

    assign th_push_c = in_src_valid & out_src_ready;
    assign fh_pop_c  = out_snk_valid & in_snk_ready;

    byte_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_to_host_fifo (
        .clk_i   (in_clk),
        .rst_n_i (rst_core_n),
        .push_i  (th_push_c),
        .wdata_i (in_src_data),
        .pop_i   (th_pop_c),
        .rdata_o (th_rdata),
        .full_o  (th_full),
        .empty_o (th_empty)
    );

    byte_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_from_host_fifo (
        .clk_i   (in_clk),
        .rst_n_i (rst_core_n),
        .push_i  (fh_push_c),
        .wdata_i (data_s),
        .pop_i   (fh_pop_c),
        .rdata_o (fh_rdata),
        .full_o  (fh_full),
        .empty_o (fh_empty)
    );

    assign out_rxf_n     = rxf_n_q;
    assign out_txe_n     = txe_n_q;
    assign out_collision = collision_q;
    assign out_src_ready = ~th_full & rst_core_n;
    assign out_snk_valid = ~fh_empty;
    assign out_snk_data  = fh_rdata;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Scoreboard bench for ft245_fifo_responder: host strobes plus src/snk streams.
module tb_ft245_fifo_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [7:0] src_data = 8'h00;
    logic       src_valid = 1'b0;
    logic       snk_ready = 1'b0;
    logic       host_drv = 1'b0;
    logic [7:0] host_data = 8'h00;
    tri1  [7:0] io_data;
    wire        rxf_n, txe_n, src_ready, snk_valid, collision;
    wire  [7:0] snk_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] th_q[$];
    logic [7:0] fh_q[$];

    assign io_data = host_drv ? host_data : 8'hzz;

    always #5 clk = ~clk;

    ft245_fifo_responder dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_rd_n       (rd_n),
        .in_wr_n       (wr_n),
        .out_rxf_n     (rxf_n),
        .out_txe_n     (txe_n),
        .io_data       (io_data),
        .in_src_data   (src_data),
        .in_src_valid  (src_valid),
        .out_src_ready (src_ready),
        .out_snk_data  (snk_data),
        .out_snk_valid (snk_valid),
        .in_snk_ready  (snk_ready),
        .out_collision (collision)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rxf_low();
        for (int i = 0; i < 40 && rxf_n !== 1'b0; i++) tick(1);
        check_val("rxf_ready", rxf_n, 0);
    endtask

    task automatic wait_txe_low();
        for (int i = 0; i < 40 && txe_n !== 1'b0; i++) tick(1);
        check_val("txe_ready", txe_n, 0);
    endtask

    task automatic src_push(input logic [7:0] b);
        src_data  = b;
        src_valid = 1'b1;
        for (int i = 0; i < 40 && src_ready !== 1'b1; i++) tick(1);
        check_val("src_ready", src_ready, 1);
        tick(1);
        src_valid = 1'b0;
        th_q.push_back(b);
    endtask

    // Host read strobe: 6 clocks low, then 6 high; checks data and rxf hold.
    task automatic host_read(input string tag);
        logic [31:0] exp;
        wait_rxf_low();
        rd_n = 1'b0;
        tick(6);
        @(negedge clk);
        exp = (th_q.size() > 0) ? 32'(th_q.pop_front()) : 32'hDEAD;
        check_val(tag, io_data, exp);
        @(posedge clk);
        #1;
        rd_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("rd_hold_rxf", rxf_n, 1);
        end
        check_val("rd_bus_release", io_data, 8'hFF);
        tick(2);
    endtask

    task automatic host_write(input logic [7:0] b, input bit accept);
        host_data = b;
        host_drv  = 1'b1;
        wr_n      = 1'b0;
        tick(6);
        wr_n      = 1'b1;
        host_drv  = 1'b0;
        tick(6);
        if (accept) fh_q.push_back(b);
    endtask

    task automatic snk_pop_one(input string tag);
        logic [31:0] exp;
        for (int i = 0; i < 40 && snk_valid !== 1'b1; i++) tick(1);
        check_val("snk_valid", snk_valid, 1);
        exp = (fh_q.size() > 0) ? 32'(fh_q.pop_front()) : 32'hDEAD;
        check_val(tag, snk_data, exp);
        snk_ready = 1'b1;
        tick(1);
        snk_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        // Reset with a pending src push that must not land
        src_data  = 8'hDE;
        src_valid = 1'b1;
        tick(5);
        check_val("rst_rxf", rxf_n, 1);
        check_val("rst_txe", txe_n, 1);
        check_val("rst_bus", io_data, 8'hFF);
        check_val("rst_snk_valid", snk_valid, 0);
        check_val("rst_collision", collision, 0);
        src_valid = 1'b0;
        rst_n = 1'b1;
        tick(4);
        check_val("post_rst_rxf", rxf_n, 1);
        check_val("post_rst_txe", txe_n, 0);

        // Host reads two bytes pushed from the src stream
        src_push(8'hA5);
        src_push(8'h3C);
        host_read("read_byte0");
        host_read("read_byte1");
        tick(6);
        check_val("read_empty_rxf", rxf_n, 1);

        // Host writes three bytes; sink stalled first
        for (int i = 0; i < 3; i++) begin
            wait_txe_low();
            host_write(8'((i + 1) * 8'h11), 1'b1);
        end
        tick(5);
        check_val("snk_stall_valid", snk_valid, 1);
        check_val("snk_stall_data", snk_data, 8'h11);
        tick(5);
        check_val("snk_stall_data2", snk_data, 8'h11);
        for (int i = 0; i < 3; i++) snk_pop_one("snk_order");
        tick(2);
        check_val("snk_drained", snk_valid, 0);

        // Fill from-host FIFO; the byte after full is dropped
        for (int i = 0; i < 128; i++) begin
            wait_txe_low();
            host_write(8'(i), 1'b1);
        end
        check_val("full_txe", txe_n, 1);
        host_write(8'hEE, 1'b0);
        check_val("full_txe_after_drop", txe_n, 1);
        snk_pop_one("full_first_pop");
        wait_txe_low();
        for (int i = 0; i < 127; i++) snk_pop_one("full_drain");
        tick(2);
        check_val("full_drop_gone", snk_valid, 0);

        // Write strobe during a read: single collision pulse, no push
        src_push(8'h77);
        wait_rxf_low();
        rd_n = 1'b0;
        tick(6);
        wr_n = 1'b0;
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (collision === 1'b1) hi++;
        end
        check_val("coll_pulses", 32'(hi), 1);
        check_val("coll_read_data", io_data, 32'(th_q.pop_front()));
        @(posedge clk);
        #1;
        wr_n = 1'b1;
        rd_n = 1'b1;
        tick(8);
        check_val("coll_fh_empty", snk_valid, 0);
        check_val("coll_txe", txe_n, 0);

        // Reset while the host is mid-read
        src_push(8'h55);
        src_push(8'h66);
        wait_rxf_low();
        rd_n = 1'b0;
        tick(6);
        @(negedge clk);
        check_val("rst_mid_data", io_data, 32'(th_q[0]));
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_bus", io_data, 8'hFF);
        check_val("rst_mid_rxf", rxf_n, 1);
        th_q.delete();
        tick(2);
        rd_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        check_val("rst_mid_th_empty", rxf_n, 1);
        check_val("rst_mid_txe", txe_n, 0);
        check_val("rst_mid_snk", snk_valid, 0);
        src_push(8'hC3);
        host_read("post_rst_read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
